priority_control_logic: RTL
===========================

PRIORITY_CONTROL_LOGIC -- requirements
Module: priority_control_logic

Interface
REQ-001 Parameter NUM_IRQ, default 8, number of request channels; power of two, 2..64.
REQ-002 Parameter DATA_W, default 8, vector/poll word width; IDX_W = log2(NUM_IRQ) SHALL satisfy IDX_W <= DATA_W-1.
REQ-003 clock  in  1  sole clock, all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 irq  in  NUM_IRQ  raw interrupt requests.
REQ-006 level_or_edge_triggered_config  in  1  1 = level, 0 = rising edge.
REQ-007 auto_eoi_config  in  1  clear ISR at end of acknowledge.
REQ-008 vector_base  in  DATA_W  vector upper bits; low IDX_W bits ignored.
REQ-009 write_mask / mask_data  in  1 / NUM_IRQ  one-cycle mask load.
REQ-010 write_eoi, eoi_specific, eoi_rotate, eoi_level  in  1,1,1,IDX_W  one-cycle EOI command.
REQ-011 poll_request  in  1  one-cycle poll command.
REQ-012 interrupt_acknowledge_n  in  1  CPU INTA, synchronous to clock.
REQ-013 interrupt_to_cpu  out  1  registered INT.
REQ-014 out_control_logic_data / control_logic_data  out  1 / DATA_W  data-bus drive enable and value.
REQ-015 interrupt_request, in_service, interrupt_mask  out  NUM_IRQ each  IRR, ISR, IMR.

Function
REQ-016 Edge mode: IRR bit SHALL set one cycle after irq sampled 0 then 1; cleared only when acknowledged or polled.
REQ-017 Level mode: IRR SHALL equal irq registered each cycle.
REQ-018 Priority SHALL start at index (priority_rotate+1) mod NUM_IRQ and descend cyclically; priority_rotate resets to NUM_IRQ-1 (index 0 highest).
REQ-019 Winner = highest-priority bit of IRR & ~IMR strictly higher than every set ISR bit (fully nested); none if no such bit.
REQ-020 interrupt_to_cpu SHALL be 1 the cycle after a winner exists in IDLE, 0 otherwise.
REQ-021 FSM states IDLE, ACK1, GAP, ACK2, POLL; INTA edges detected against previous-cycle sample.
REQ-022 IDLE -> ACK1 on INTA falling edge: latch winner index, set its ISR bit, clear its IRR bit (edge mode); no winner -> latch index NUM_IRQ-1, spurious flag, ISR unchanged.
REQ-023 ACK1 -> GAP on INTA rising edge; GAP -> ACK2 on falling edge; ACK2 -> IDLE on rising edge.
REQ-024 During ACK2 with INTA low, out_control_logic_data = 1 and control_logic_data = {vector_base[DATA_W-1:IDX_W], latched index}; all other states drive 0 and 0.
REQ-025 ACK2 exit with auto_eoi_config = 1 and not spurious SHALL clear the latched ISR bit.
REQ-026 IDLE with poll_request -> POLL for exactly one cycle: out_control_logic_data = 1, control_logic_data = {1, zeros, winner index} with winner-side ISR set/IRR clear as REQ-022, or all zeros if no winner; then IDLE.
REQ-027 poll_request outside IDLE SHALL be ignored.
REQ-028 write_eoi with eoi_specific = 1 clears ISR[eoi_level]; with 0 clears highest-priority set ISR bit; no set bit -> no change.
REQ-029 write_eoi with eoi_rotate = 1 and a bit cleared SHALL set priority_rotate to that index.
REQ-030 write_mask SHALL update IMR next cycle; same-cycle INTA/poll resolution uses old IMR.
REQ-031 Simultaneous set and clear of one IRR bit (new edge during acknowledge): set wins; ISR set and EOI clear of same bit: set wins.
REQ-032 write_eoi accepted in every state.

Reset
REQ-033 reset_n low SHALL immediately force: IRR 0, ISR 0, IMR all ones, priority_rotate NUM_IRQ-1, state IDLE, interrupt_to_cpu 0, out_control_logic_data 0, control_logic_data 0, edge history 0; reset mid-acknowledge abandons the sequence without further ISR change.

Verification
REQ-034 Edge mode, IMR=0, irq[3] 0->1, vector_base=0x40, two INTA pulses -> INT 1, second pulse data 0x43, ISR=0x08, IRR=0x00.
REQ-035 irq[2] and irq[5] pending, non-specific rotating EOI after ack of 2 -> priority_rotate=2, next ack returns index 5 before 2.
REQ-036 INTA with no unmasked request -> vector low bits 7, ISR unchanged, INT 0.
REQ-037 ISR[1] set, irq[4] pending -> INT 0; specific EOI level 1 -> INT 1 next cycle.
REQ-038 poll_request with irq[6] pending -> one cycle data 0x86, ISR[6]=1; with none pending -> data 0x00.
REQ-039 reset_n low during GAP -> all outputs reset values; ISR=0, state IDLE.

Source files
------------

// File: rtl/priority_control_logic_if.sv
// Bus bundle between the CPU-side agent and the priority interrupt controller.
interface priority_control_logic_if #(
   parameter int NUM_IRQ = 8,
   parameter int DATA_W  = 8
);
   localparam int IDX_W = $clog2(NUM_IRQ);

   logic [NUM_IRQ-1:0] irq;
   logic               level_or_edge_triggered_config;
   logic               auto_eoi_config;
   logic [DATA_W-1:0]  vector_base;
   logic               write_mask;
   logic [NUM_IRQ-1:0] mask_data;
   logic               write_eoi;
   logic               eoi_specific;
   logic               eoi_rotate;
   logic [IDX_W-1:0]   eoi_level;
   logic               poll_request;
   logic               interrupt_acknowledge_n;

   logic               interrupt_to_cpu;
   logic               out_control_logic_data;
   logic [DATA_W-1:0]  control_logic_data;
   logic [NUM_IRQ-1:0] interrupt_request;
   logic [NUM_IRQ-1:0] in_service;
   logic [NUM_IRQ-1:0] interrupt_mask;

   modport master (
      output irq, level_or_edge_triggered_config, auto_eoi_config, vector_base,
             write_mask, mask_data, write_eoi, eoi_specific, eoi_rotate, eoi_level,
             poll_request, interrupt_acknowledge_n,
      input  interrupt_to_cpu, out_control_logic_data, control_logic_data,
             interrupt_request, in_service, interrupt_mask
   );

   modport slave (
      input  irq, level_or_edge_triggered_config, auto_eoi_config, vector_base,
             write_mask, mask_data, write_eoi, eoi_specific, eoi_rotate, eoi_level,
             poll_request, interrupt_acknowledge_n,
      output interrupt_to_cpu, out_control_logic_data, control_logic_data,
             interrupt_request, in_service, interrupt_mask
   );
endinterface

// File: rtl/priority_control_logic.sv
// Priority interrupt controller: IRR/ISR/IMR, rotating fully-nested priority,
// two-pulse INTA vector delivery, poll command and EOI handling.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting; INT reflects winner; INTA fall or poll accepted
// ACK1   | first INTA pulse low; winner latched, ISR set
// GAP    | INTA high between the two pulses
// ACK2   | second INTA pulse; vector driven while INTA low
// POLL   | one cycle driving the poll word, then back to IDLE
module priority_control_logic #(
   parameter int NUM_IRQ = 8,
   parameter int DATA_W  = 8
) (
   input logic                    clock,
   input logic                    reset_n,
   priority_control_logic_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_IRQ);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ACK1 = 3'd1,
      S_GAP  = 3'd2,
      S_ACK2 = 3'd3,
      S_POLL = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_IRQ-1:0] irr_q, isr_q, imr_q, irq_prev_q;
   logic [NUM_IRQ-1:0] irr_d, isr_d;
   logic [IDX_W-1:0]   rot_q;
   logic [IDX_W-1:0]   ack_idx_q, ack_idx_d;
   logic               spurious_q, spurious_d;
   logic [DATA_W-1:0]  poll_word_q, poll_word_d;
   logic               inta_prev_q;
   logic               int_q;

   logic               inta, inta_fall, inta_rise;
   logic [NUM_IRQ-1:0] req_vec;
   logic               req_found, isr_found;
   logic [IDX_W-1:0]   req_idx, req_lvl, isr_idx, isr_lvl;
   logic               win_valid;
   logic [NUM_IRQ-1:0] ack_set, auto_clr, eoi_clr;
   logic               eoi_hit;
   logic [IDX_W-1:0]   eoi_idx;
   logic               unused_vector_low;

   // The low vector_base bits are replaced by the index on the bus.
   assign unused_vector_low = ^bus.vector_base[IDX_W-1:0];

   function automatic logic [NUM_IRQ-1:0] onehot(input logic [IDX_W-1:0] i);
      return NUM_IRQ'(1) << i;
   endfunction

   assign inta      = bus.interrupt_acknowledge_n;
   assign inta_fall = inta_prev_q & ~inta;
   assign inta_rise = ~inta_prev_q & inta;
   assign req_vec   = irr_q & ~imr_q;

   // Scan from the current top-priority index downward; level 0 is highest.
   always_comb begin
      logic [IDX_W-1:0] cand;
      req_found = 1'b0;
      req_idx   = '0;
      req_lvl   = '0;
      isr_found = 1'b0;
      isr_idx   = '0;
      isr_lvl   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_IRQ; k++) begin
         cand = IDX_W'(int'(rot_q) + k + 1);
         if (!req_found && req_vec[cand]) begin
            req_found = 1'b1;
            req_idx   = cand;
            req_lvl   = IDX_W'(k);
         end
         if (!isr_found && isr_q[cand]) begin
            isr_found = 1'b1;
            isr_idx   = cand;
            isr_lvl   = IDX_W'(k);
         end
      end
   end

   // Fully nested: a request only wins if strictly above every in-service bit.
   assign win_valid = req_found && (!isr_found || (req_lvl < isr_lvl));

   // EOI decode; a specific EOI on an idle ISR bit does nothing (no rotate either).
   always_comb begin
      eoi_hit = 1'b0;
      eoi_idx = '0;
      if (bus.write_eoi) begin
         if (bus.eoi_specific) begin
            if (isr_q[bus.eoi_level]) begin
               eoi_hit = 1'b1;
               eoi_idx = bus.eoi_level;
            end
         end else if (isr_found) begin
            eoi_hit = 1'b1;
            eoi_idx = isr_idx;
         end
      end
      eoi_clr = eoi_hit ? onehot(eoi_idx) : '0;
   end

   // Next-state and acknowledge/poll side effects.
   always_comb begin
      state_d     = state_q;
      ack_idx_d   = ack_idx_q;
      spurious_d  = spurious_q;
      poll_word_d = poll_word_q;
      ack_set     = '0;
      auto_clr    = '0;
      case (state_q)
         S_IDLE: begin
            if (inta_fall) begin
               state_d = S_ACK1;
               if (win_valid) begin
                  ack_idx_d  = req_idx;
                  spurious_d = 1'b0;
                  ack_set    = onehot(req_idx);
               end else begin
                  ack_idx_d  = '1;
                  spurious_d = 1'b1;
               end
            end else if (bus.poll_request) begin
               state_d     = S_POLL;
               poll_word_d = '0;
               if (win_valid) begin
                  poll_word_d[DATA_W-1]  = 1'b1;
                  poll_word_d[IDX_W-1:0] = req_idx;
                  ack_set                = onehot(req_idx);
               end
            end
         end
         S_ACK1: begin
            if (inta_rise) state_d = S_GAP;
         end
         S_GAP: begin
            if (inta_fall) state_d = S_ACK2;
         end
         S_ACK2: begin
            if (inta_rise) begin
               state_d = S_IDLE;
               if (bus.auto_eoi_config && !spurious_q) auto_clr = onehot(ack_idx_q);
            end
         end
         S_POLL: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Set beats clear on both registers when they collide on one bit.
   always_comb begin
      if (bus.level_or_edge_triggered_config) begin
         irr_d = bus.irq;
      end else begin
         irr_d = (irr_q & ~ack_set) | (bus.irq & ~irq_prev_q);
      end
      isr_d = (isr_q & ~(eoi_clr | auto_clr)) | ack_set;
   end

   // State, request/service/mask registers, rotation and edge history.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         irr_q       <= '0;
         isr_q       <= '0;
         imr_q       <= '1;
         irq_prev_q  <= '0;
         rot_q       <= IDX_W'(NUM_IRQ - 1);
         ack_idx_q   <= '0;
         spurious_q  <= 1'b0;
         poll_word_q <= '0;
         inta_prev_q <= 1'b0;
         int_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         irr_q       <= irr_d;
         isr_q       <= isr_d;
         irq_prev_q  <= bus.irq;
         ack_idx_q   <= ack_idx_d;
         spurious_q  <= spurious_d;
         poll_word_q <= poll_word_d;
         inta_prev_q <= inta;
         int_q       <= (state_q == S_IDLE) && win_valid;
         if (bus.write_mask) imr_q <= bus.mask_data;
         if (eoi_hit && bus.eoi_rotate) rot_q <= eoi_idx;
      end
   end

   // Data bus: vector only while the second INTA pulse is low, poll word in POLL.
   always_comb begin
      bus.out_control_logic_data = 1'b0;
      bus.control_logic_data     = '0;
      if ((state_q == S_ACK2) && !inta) begin
         bus.out_control_logic_data = 1'b1;
         bus.control_logic_data     = {bus.vector_base[DATA_W-1:IDX_W], ack_idx_q};
      end else if (state_q == S_POLL) begin
         bus.out_control_logic_data = 1'b1;
         bus.control_logic_data     = poll_word_q;
      end
   end

   assign bus.interrupt_to_cpu  = int_q;
   assign bus.interrupt_request = irr_q;
   assign bus.in_service        = isr_q;
   assign bus.interrupt_mask    = imr_q;

endmodule
